// File: rtl/overlay_draw_engine_if.sv
// Command, font-ROM and overlay-RAM signals of overlay_draw_engine, bundled.
//   slave  : engine side (takes the command and font data, drives ready, ROM address and writes)
//   master : controller / memory side
// Signals: i_cmd_valid/o_cmd_ready handshake, i_ascii, i_color, i_ys/i_ye (clear rows),
//          i_x/i_y (glyph origin), i_x1/i_y1/i_x2/i_y2 (rectangle corners),
//          o_font_addr/i_font_data (font ROM), o_wr_en/o_wr_addr/o_wr_data (RAM), o_busy.
interface overlay_draw_engine_if #(
  parameter int unsigned L_W = 8,
  parameter int unsigned A_W = 8
);
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [A_W-1:0] i_ascii;
  logic [2:0]     i_color;
  logic [L_W-1:0] i_ys, i_ye;
  logic [L_W-1:0] i_x, i_y;
  logic [L_W-1:0] i_x1, i_y1, i_x2, i_y2;
  logic [11:0]    o_font_addr;
  logic [7:0]     i_font_data;
  logic           o_wr_en;
  logic [15:0]    o_wr_addr;
  logic [2:0]     o_wr_data;
  logic           o_busy;

  modport slave (
    input  i_cmd_valid, i_ascii, i_color, i_ys, i_ye, i_x, i_y, i_x1, i_y1, i_x2, i_y2,
    input  i_font_data,
    output o_cmd_ready, o_font_addr, o_wr_en, o_wr_addr, o_wr_data, o_busy
  );

  modport master (
    output i_cmd_valid, i_ascii, i_color, i_ys, i_ye, i_x, i_y, i_x1, i_y1, i_x2, i_y2,
    output i_font_data,
    input  o_cmd_ready, o_font_addr, o_wr_en, o_wr_addr, o_wr_data, o_busy
  );
endinterface

// File: rtl/overlay_draw_engine.sv
// Overlay draw engine: executes one command at a time into a 256x256 colour overlay RAM.
//   ascii 0 : clear rows ys..ye to colour 0
//   ascii 1 : rectangle outline (x1,y1)-(x2,y2), inclusive
//   ascii>=2: 8x16 glyph from the font ROM at (x,y), transparent background
// Ports: sys_clk, sys_rst_n (async, active-low), bus (overlay_draw_engine_if.slave).
// Writes are registered and appear one cycle after the state cycle that issues them.
// Build option: OVERLAY_CLIP_EN drops glyph pixels past the frame edge instead of
// wrapping them modulo 256; glyph timing is unchanged either way.
module overlay_draw_engine #(
  parameter int unsigned L_W = 8,
  parameter int unsigned A_W = 8
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  overlay_draw_engine_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StClear, StRTop, StRBot, StRLeft, StRRight, StGFetch, StGWait, StGRow
  } state_e;

  state_e         state_q, state_d;
  logic [A_W-1:0] ascii_q, ascii_d;
  logic [2:0]     color_q, color_d;
  logic [L_W-1:0] ye_q, ye_d;
  logic [L_W-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [L_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [L_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [3:0]     row_q, row_d;
  logic [2:0]     col_q, col_d;
  logic [7:0]     font_q, font_d;
  logic           ready_q, ready_d;
  logic           wr_en_q, wr_en_d;
  logic [15:0]    wr_addr_q, wr_addr_d;
  logic [2:0]     wr_data_q, wr_data_d;
  logic [L_W:0]   px_sum, py_sum;

  always_comb begin
    state_d   = state_q;
    ascii_d   = ascii_q;
    color_d   = color_q;
    ye_d      = ye_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    x2_d      = x2_q;
    y2_d      = y2_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    row_d     = row_q;
    col_d     = col_q;
    font_d    = font_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    // Extra MSB flags a glyph pixel that ran past the frame edge.
    px_sum    = (L_W+1)'(gx_q) + (L_W+1)'(col_q);
    py_sum    = (L_W+1)'(gy_q) + (L_W+1)'(row_q);

    case (state_q)
      StIdle: begin
        if (bus.i_cmd_valid && ready_q) begin
          ascii_d = bus.i_ascii;
          color_d = bus.i_color;
          ye_d    = bus.i_ye;
          x1_d    = bus.i_x1;
          y1_d    = bus.i_y1;
          x2_d    = bus.i_x2;
          y2_d    = bus.i_y2;
          gx_d    = bus.i_x;
          gy_d    = bus.i_y;
          row_d   = 4'd0;
          col_d   = 3'd0;
          if (bus.i_ascii == '0) begin
            state_d = StClear;
            cx_d    = '0;
            cy_d    = bus.i_ys;
          end else if (bus.i_ascii == A_W'(1)) begin
            state_d = StRTop;
            cx_d    = bus.i_x1;
          end else begin
            state_d = StGFetch;
          end
        end
      end

      StClear: begin
        // cy only exceeds ye here when the command arrived with ys > ye.
        if (cy_q > ye_q) begin
          state_d = StIdle;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = 16'({cy_q, cx_q});
          wr_data_d = 3'd0;
          cx_d      = cx_q + L_W'(1);
          if (cx_q == '1) begin
            if (cy_q == ye_q) state_d = StIdle;
            else              cy_d    = cy_q + L_W'(1);
          end
        end
      end

      StRTop: begin
        if (x1_q > x2_q || y1_q > y2_q) begin
          state_d = StIdle;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = 16'({y1_q, cx_q});
          wr_data_d = color_q;
          cx_d      = cx_q + L_W'(1);
          if (cx_q == x2_q) begin
            if (y1_q == y2_q) begin
              state_d = StIdle;
            end else begin
              state_d = StRBot;
              cx_d    = x1_q;
            end
          end
        end
      end

      StRBot: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 16'({y2_q, cx_q});
        wr_data_d = color_q;
        cx_d      = cx_q + L_W'(1);
        if (cx_q == x2_q) begin
          if ((y2_q - y1_q) >= L_W'(2)) begin
            state_d = StRLeft;
            cy_d    = y1_q + L_W'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end

      StRLeft: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 16'({cy_q, x1_q});
        wr_data_d = color_q;
        cy_d      = cy_q + L_W'(1);
        if (cy_q == y2_q - L_W'(1)) begin
          if (x1_q == x2_q) begin
            state_d = StIdle;
          end else begin
            state_d = StRRight;
            cy_d    = y1_q + L_W'(1);
          end
        end
      end

      StRRight: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 16'({cy_q, x2_q});
        wr_data_d = color_q;
        cy_d      = cy_q + L_W'(1);
        if (cy_q == y2_q - L_W'(1)) state_d = StIdle;
      end

      StGFetch: state_d = StGWait;

      StGWait: begin
        font_d  = bus.i_font_data;
        col_d   = 3'd0;
        state_d = StGRow;
      end

      StGRow: begin
        // Bit 7 is the leftmost pixel, so column c reads bit ~c.
`ifdef OVERLAY_CLIP_EN
        wr_en_d = font_q[~col_q] & ~px_sum[L_W] & ~py_sum[L_W];
`else
        wr_en_d = font_q[~col_q];
`endif
        wr_addr_d = 16'({py_sum[L_W-1:0], px_sum[L_W-1:0]});
        wr_data_d = color_q;
        col_d     = col_q + 3'd1;
        if (col_q == 3'd7) begin
          if (row_q == 4'd15) begin
            state_d = StIdle;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = StGFetch;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Registered so ready stays low while reset is asserted.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      ascii_q   <= '0;
      color_q   <= '0;
      ye_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      font_q    <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ascii_q   <= ascii_d;
      color_q   <= color_d;
      ye_q      <= ye_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      row_q     <= row_d;
      col_q     <= col_d;
      font_q    <= font_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.o_cmd_ready = ready_q;
  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_font_addr = {ascii_q[7:0], row_q};
  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;

endmodule

// File: tb/tb_overlay_draw_engine.sv
module tb_overlay_draw_engine;

  localparam int Limit = 70000;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  overlay_draw_engine_if #(.L_W(8), .A_W(8)) bus ();

  overlay_draw_engine #(.L_W(8), .A_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int font_mode = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_w;
  int          n_wr = 0;
  logic [15:0] first_addr, last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Font ROM contents as a function of address, selectable per test.
  function automatic logic [7:0] font_fn(input logic [11:0] a);
    logic [31:0] h;
    case (font_mode)
      0:       return 8'h81;
      1:       return 8'hFF;
      default: begin
        h = {20'd0, a} * 32'h9E37 + 32'h1234;
        return h[15:8] ^ h[7:0];
      end
    endcase
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge sys_clk) bus.i_font_data <= font_fn(bus.o_font_addr);

  // Compare every write the engine makes against the expected stream.
  always @(negedge sys_clk) begin
    if (sys_rst_n && bus.o_wr_en === 1'b1) begin
      if (n_wr == 0) first_addr = bus.o_wr_addr;
      last_addr = bus.o_wr_addr;
      n_wr++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data %0d, expected none at %0t",
                 bus.o_wr_addr, bus.o_wr_data, $time);
      end else begin
        exp_w = exp_q.pop_front();
        check("wr_addr", 32'(bus.o_wr_addr), 32'(exp_w.addr));
        check("wr_data", 32'(bus.o_wr_data), 32'(exp_w.data));
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push(input int y, input int x, input int c);
    wr_t w;
    w.addr = {8'(y), 8'(x)};
    w.data = 3'(c);
    exp_q.push_back(w);
  endtask

  task automatic model_clear(input int ys, input int ye);
    for (int y = ys; y <= ye; y++)
      for (int x = 0; x < 256; x++) push(y, x, 0);
  endtask

  task automatic model_rect(input int x1, input int y1, input int x2, input int y2, input int c);
    if (x1 > x2 || y1 > y2) return;
    for (int x = x1; x <= x2; x++) push(y1, x, c);
    if (y2 != y1) for (int x = x1; x <= x2; x++) push(y2, x, c);
    if (y2 - y1 >= 2) begin
      for (int y = y1 + 1; y < y2; y++) push(y, x1, c);
      if (x1 != x2) for (int y = y1 + 1; y < y2; y++) push(y, x2, c);
    end
  endtask

  task automatic model_glyph(input int a, input int x, input int y, input int c);
    logic [7:0] bits;
    for (int r = 0; r < 16; r++) begin
      bits = font_fn({8'(a), 4'(r)});
      for (int col = 0; col < 8; col++) begin
        if (bits[7-col]) begin
`ifdef OVERLAY_CLIP_EN
          if (x + col <= 255 && y + r <= 255) push((y + r) % 256, (x + col) % 256, c);
`else
          push((y + r) % 256, (x + col) % 256, c);
`endif
        end
      end
    end
  endtask

  // Issue one command, check its duration, write count and that all expected writes arrived.
  // Call aligned to posedge+1; returns aligned to posedge+1.
  task automatic run_cmd(input int a, input int c, input int ys, input int ye, input int x,
                         input int y, input int x1, input int y1, input int x2, input int y2,
                         input bit hold);
    int cnt;
    int exp_n;
    int exp_cycles;
    exp_q.delete();
    if (a == 0)      model_clear(ys, ye);
    else if (a == 1) model_rect(x1, y1, x2, y2, c);
    else             model_glyph(a, x, y, c);
    exp_n = exp_q.size();
    exp_cycles = (a >= 2) ? 160 : ((exp_n == 0) ? 1 : exp_n);
    n_wr = 0;
    cnt = 0;
    while (bus.o_cmd_ready !== 1'b1 && cnt < Limit) begin
      @(posedge sys_clk); #1; cnt++;
    end
    check("ready_before_cmd", 32'(bus.o_cmd_ready), 32'd1);
    bus.i_ascii = 8'(a); bus.i_color = 3'(c);
    bus.i_ys = 8'(ys); bus.i_ye = 8'(ye); bus.i_x = 8'(x); bus.i_y = 8'(y);
    bus.i_x1 = 8'(x1); bus.i_y1 = 8'(y1); bus.i_x2 = 8'(x2); bus.i_y2 = 8'(y2);
    bus.i_cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    if (hold) begin
      // Keep valid asserted with different fields; the engine must ignore them while busy.
      bus.i_ascii = 8'($urandom_range(0, 255)); bus.i_color = 3'($urandom);
      bus.i_ys = 8'($urandom); bus.i_ye = 8'($urandom); bus.i_x = 8'($urandom);
      bus.i_y = 8'($urandom); bus.i_x1 = 8'($urandom); bus.i_y1 = 8'($urandom);
      bus.i_x2 = 8'($urandom); bus.i_y2 = 8'($urandom);
    end else begin
      bus.i_cmd_valid = 1'b0;
    end
    check("busy_after_accept", 32'(bus.o_busy), 32'd1);
    cnt = 0;
    while (bus.o_cmd_ready !== 1'b1 && cnt < Limit) begin
      @(posedge sys_clk); #1; cnt++;
    end
    bus.i_cmd_valid = 1'b0;
    check("cmd_cycles", 32'(cnt), 32'(exp_cycles));
    @(negedge sys_clk); #1;
    check("write_count", 32'(n_wr), 32'(exp_n));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    int a, c, ys, ye, x, y, x1, y1, x2, y2, kind;
    bus.i_cmd_valid = 1'b0;
    bus.i_ascii = '0; bus.i_color = '0; bus.i_ys = '0; bus.i_ye = '0;
    bus.i_x = '0; bus.i_y = '0; bus.i_x1 = '0; bus.i_y1 = '0; bus.i_x2 = '0; bus.i_y2 = '0;

    // Reset state.
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ready", 32'(bus.o_cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.o_wr_data), 32'd0);
    check("rst_font_addr", 32'(bus.o_font_addr), 32'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("ready_after_release", 32'(bus.o_cmd_ready), 32'd1);

    // Clear rows 128..191.
    run_cmd(0, 0, 128, 191, 0, 0, 0, 0, 0, 0, 1'b0);
    check("clear_n", 32'(n_wr), 32'd16384);
    check("clear_first", 32'(first_addr), 32'h8000);
    check("clear_last", 32'(last_addr), 32'hBFFF);

    // Clear with ys > ye: no writes, one cycle.
    run_cmd(0, 0, 10, 9, 0, 0, 0, 0, 0, 0, 1'b0);
    check("clear_empty_n", 32'(n_wr), 32'd0);

    // Rectangle (10,20)-(13,22).
    run_cmd(1, 5, 0, 0, 0, 0, 10, 20, 13, 22, 1'b0);
    check("rect_n", 32'(n_wr), 32'd10);
    check("rect_first", 32'(first_addr), 32'h140A);
    check("rect_last", 32'(last_addr), 32'h150D);

    // Degenerate rectangles.
    run_cmd(1, 3, 0, 0, 0, 0, 7, 7, 7, 7, 1'b0);
    check("rect_point_n", 32'(n_wr), 32'd1);
    run_cmd(1, 3, 0, 0, 0, 0, 7, 5, 7, 9, 1'b0);
    check("rect_vline_n", 32'(n_wr), 32'd5);
    run_cmd(1, 3, 0, 0, 0, 0, 20, 5, 10, 9, 1'b0);
    check("rect_inverted_n", 32'(n_wr), 32'd0);

    // Glyph 0x41 at (8,16), rows 0x81.
    font_mode = 0;
    run_cmd(8'h41, 6, 0, 0, 8, 16, 0, 0, 0, 0, 1'b0);
    check("glyph_n", 32'(n_wr), 32'd32);
    check("glyph_first", 32'(first_addr), 32'h1008);
    check("glyph_last", 32'(last_addr), 32'h1F0F);

    // Glyph at the frame corner, rows 0xFF.
    font_mode = 1;
    run_cmd(8'h41, 2, 0, 0, 252, 250, 0, 0, 0, 0, 1'b0);
    check("corner_first", 32'(first_addr), 32'hFAFC);
`ifdef OVERLAY_CLIP_EN
    check("corner_n", 32'(n_wr), 32'd24);
    check("corner_last", 32'(last_addr), 32'hFFFF);
`else
    check("corner_n", 32'(n_wr), 32'd128);
    check("corner_last", 32'(last_addr), 32'h0903);
`endif

    // Valid held high while busy: only the first command runs.
    run_cmd(1, 4, 0, 0, 0, 0, 30, 40, 35, 44, 1'b1);
    check("hold_busy_after", 32'(bus.o_busy), 32'd0);

    // Reset in the middle of a clear.
    exp_q.delete();
    model_clear(0, 255);
    n_wr = 0;
    bus.i_ascii = 8'd0; bus.i_ys = 8'd0; bus.i_ye = 8'd255; bus.i_cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    bus.i_cmd_valid = 1'b0;
    repeat (100) begin
      @(posedge sys_clk); #1;
    end
    check("pre_reset_writes", 32'(n_wr), 32'd99);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_ready", 32'(bus.o_cmd_ready), 32'd0);
    exp_q.delete();
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("postrst_ready", 32'(bus.o_cmd_ready), 32'd1);
    repeat (5) begin
      @(posedge sys_clk); #1;
    end
    check("postrst_busy", 32'(bus.o_busy), 32'd0);
    run_cmd(1, 7, 0, 0, 0, 0, 1, 2, 6, 8, 1'b0);
    check("postrst_rect_n", 32'(n_wr), 32'd22);

    // Randomized commands.
    font_mode = 2;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      c  = $urandom_range(0, 7);
      ys = 0; ye = 0; x = 0; y = 0; x1 = 0; y1 = 0; x2 = 0; y2 = 0;
      if (kind == 0) begin
        a = 0;
        ys = $urandom_range(0, 255);
        if ($urandom_range(0, 4) == 0 && ys > 0) ye = ys - $urandom_range(1, ys);
        else ye = (ys + $urandom_range(0, 2) > 255) ? 255 : ys + $urandom_range(0, 2);
      end else if (kind == 1) begin
        a  = 1;
        x1 = $urandom_range(0, 255);
        y1 = $urandom_range(0, 255);
        x2 = x1 + $urandom_range(0, 20);
        y2 = y1 + $urandom_range(0, 12);
        if (x2 > 255) x2 = 255;
        if (y2 > 255) y2 = 255;
        if ($urandom_range(0, 5) == 0) begin
          x2 = x1; x1 = $urandom_range(0, 255);
        end
      end else begin
        a = $urandom_range(2, 255);
        x = ($urandom_range(0, 3) == 0) ? $urandom_range(248, 255) : $urandom_range(0, 255);
        y = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      end
      run_cmd(a, c, ys, ye, x, y, x1, y1, x2, y2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/overlay_draw_engine.md
OVERLAY_DRAW_ENGINE -- requirements
Module: overlay_draw_engine

Interface
REQ-001 SHALL have parameter L_W, default 8, meaning coordinate width; the frame is 256x256.
REQ-002 SHALL have parameter A_W, default 8, meaning ASCII code width.
REQ-003 SHALL have port sys_clk, input, 1 bit: clock.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_cmd_valid, input, 1 bit: command present.
REQ-006 SHALL have port o_cmd_ready, output, 1 bit: engine can accept a command.
REQ-007 SHALL have port i_ascii, input, A_W bits: 0 means clear, 1 means rectangle, 2 or more means glyph code.
REQ-008 SHALL have port i_color, input, 3 bits: draw colour.
REQ-009 SHALL have ports i_ys and i_ye, input, L_W bits each: clear start and end rows.
REQ-010 SHALL have ports i_x and i_y, input, L_W bits each: glyph top-left corner.
REQ-011 SHALL have ports i_x1, i_y1, i_x2 and i_y2, input, L_W bits each: rectangle corners, inclusive.
REQ-012 SHALL have port o_font_addr, output, 12 bits: font ROM address {ascii, row[3:0]}.
REQ-013 SHALL have port i_font_data, input, 8 bits: font row, returned 1 cycle after o_font_addr; bit7 is the leftmost pixel.
REQ-014 SHALL have port o_wr_en, output, 1 bit: overlay RAM write strobe.
REQ-015 SHALL have port o_wr_addr, output, 16 bits: RAM address {y, x}.
REQ-016 SHALL have port o_wr_data, output, 3 bits: RAM colour data.
REQ-017 SHALL have port o_busy, output, 1 bit: engine is not IDLE.

Function
REQ-018 SHALL use states IDLE, CLEAR, R_TOP, R_BOT, R_LEFT, R_RIGHT, G_FETCH, G_WAIT and G_ROW.
REQ-019 SHALL drive o_cmd_ready=1 only in IDLE, and SHALL accept a command when i_cmd_valid && o_cmd_ready; all command fields are captured in that cycle.
REQ-020 SHALL, on accept, go to CLEAR if ascii==0, R_TOP if ascii==1, and G_FETCH otherwise.
REQ-021 SHALL, in CLEAR, write data 0 row-major for rows ys..ye and columns 0..255, one write per cycle, for (ye-ys+1)*256 writes; if ys>ye it SHALL make no writes and return to IDLE the next cycle.
REQ-022 SHALL make rectangle writes of i_color, one per cycle, in this order:
  - R_TOP: row y1, x1..x2.
  - R_BOT: row y2, x1..x2.
  - R_LEFT: column x1, y1+1..y2-1.
  - R_RIGHT: column x2, y1+1..y2-1.
REQ-023 SHALL apply these rectangle degenerate rules:
  - skip R_BOT when y1==y2;
  - skip R_LEFT and R_RIGHT when y2-y1<2;
  - skip R_RIGHT when x1==x2;
  - make no writes when x1>x2 or y1>y2.
REQ-024 SHALL draw a glyph row by row for rows 0..15:
  - G_FETCH presents o_font_addr for 1 cycle.
  - G_WAIT takes 1 cycle while i_font_data becomes valid, and the row is registered.
  - G_ROW scans columns 0..7 in 8 cycles, writing i_color at (x+col, y+row) only where the bit is 1 (transparent background).
  - Each glyph takes exactly 160 cycles from accept to IDLE.
REQ-025 SHALL register o_wr_en, o_wr_addr and o_wr_data, placing each write 1 cycle after its state cycle; o_wr_en SHALL be 0 in cycles without a write.
REQ-026 SHALL compute coordinate sums modulo 256 when OVERLAY_CLIP_EN is not defined.
REQ-027 SHALL return to IDLE the cycle after the last write-issuing cycle, so back-to-back commands lose exactly 1 idle cycle.
REQ-028 SHALL ignore i_cmd_valid while busy; commands are not queued.

Reset
REQ-029 SHALL, on sys_rst_n low, go to IDLE and drive o_cmd_ready=0, o_busy=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0 and o_font_addr=0.
REQ-030 SHALL drive o_cmd_ready=1 in the first cycle after reset release.
REQ-031 SHALL, on reset mid-operation, abort the command with no further writes and no resume.

Configuration
REQ-032 SHALL, when OVERLAY_CLIP_EN is defined, suppress any glyph pixel whose x+col or y+row exceeds 255 (o_wr_en=0 for that cycle) without changing the 160-cycle timing.
REQ-033 SHALL, when OVERLAY_CLIP_EN is not defined, wrap such pixels modulo 256 per REQ-026.

Verification
REQ-034 SHALL cover clear with ys=128, ye=191 -> 16384 writes, data 0, first addr 0x8000, last addr 0xBFFF, then ready.
REQ-035 SHALL cover rectangle (10,20)-(13,22) -> writes in order (y20: x10..13), (y22: x10..13), (x10,y21), (x13,y21); 10 writes total.
REQ-036 SHALL cover glyph ascii 0x41 at (8,16) with font rows all 0x81 -> 32 writes at x 8 and 15, y 16..31, in 160 cycles.
REQ-037 SHALL cover glyph at (252,250) with rows 0xFF -> with OVERLAY_CLIP_EN, 4*6=24 writes; without it, 128 writes, wrapped.
REQ-038 SHALL cover sys_rst_n asserted mid-clear -> o_wr_en=0 immediately, IDLE after release, and the next command executes normally.
REQ-039 SHALL cover i_cmd_valid held high while busy -> only the first command executes until o_cmd_ready returns to 1.
